// File: rtl/sym_vn_lut_loader.sv
// Write-side loader for the VN LUT rank: streams bank0/bank1 entry pairs into pages
// 0..PAGE_NUM-1 of one offset region, leaving the other region free for readers.
module sym_vn_lut_loader #(
  parameter int QUAN_SIZE   = 4,
  parameter int PAGE_ADDR_W = 6,
  parameter int PAGE_NUM    = 64
) (
  input  logic                   write_clk,
  input  logic                   rstn,
  input  logic                   load_start,
  input  logic                   load_offset,
  input  logic                   load_abort,
  input  logic [QUAN_SIZE-1:0]   entry_bank0,
  input  logic [QUAN_SIZE-1:0]   entry_bank1,
  input  logic                   entry_valid,
  output logic                   entry_ready,
  output logic [QUAN_SIZE-1:0]   lut_in_bank0,
  output logic [QUAN_SIZE-1:0]   lut_in_bank1,
  output logic [PAGE_ADDR_W-1:0] page_write_addr,
  output logic                   write_addr_offset,
  output logic                   we,
  output logic                   busy,
  output logic                   load_done
);

  localparam int NUM_BANKS = 2;
  // One spare bit so the post-increment after the last page never aliases page 0.
  localparam int CNT_W = PAGE_ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_PAGE = CNT_W'(PAGE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                                 r_state;
  state_t                                 w_state_nxt;
  logic [CNT_W-1:0]                       r_cnt;
  logic [NUM_BANKS-1:0][QUAN_SIZE-1:0]    w_entry;
  logic [NUM_BANKS-1:0][QUAN_SIZE-1:0]    r_lut;
  logic [PAGE_ADDR_W-1:0]                 r_addr;
  logic                                   r_offset;
  logic                                   r_we;
  logic                                   w_ready;
  logic                                   w_accept;
  logic                                   w_last;
  logic                                   w_start;

  assign w_entry[0] = entry_bank0;
  assign w_entry[1] = entry_bank1;

  assign w_ready  = (r_state == S_LOAD) && !load_abort;
  assign w_accept = entry_valid && w_ready;
  assign w_last   = (r_cnt == LAST_PAGE);
  assign w_start  = (r_state == S_IDLE) && load_start;

  always_ff @(posedge write_clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Abort outranks a pending final accept; ready is already low under abort anyway.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (load_start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (load_abort)             w_state_nxt = S_IDLE;
        else if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_offset <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      r_we <= w_accept;
      if (w_start) begin
        r_offset <= load_offset;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_addr <= r_cnt[PAGE_ADDR_W-1:0];
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    always_ff @(posedge write_clk) begin
      if (!rstn)         r_lut[b] <= '0;
      else if (w_accept) r_lut[b] <= w_entry[b];
    end
  end

  assign entry_ready       = w_ready;
  assign lut_in_bank0      = r_lut[0];
  assign lut_in_bank1      = r_lut[1];
  assign page_write_addr   = r_addr;
  assign write_addr_offset = r_offset;
  assign we                = r_we;
  assign busy              = (r_state != S_IDLE);
  assign load_done         = (r_state == S_DONE);

endmodule
